tmds_channel_decoder: RTL and testbench

Receive-side counterpart of the DVI/TMDS serializer path: decodes one TMDS channel's 10-bit symbols, recovered by an external 1:10 deserializer in the pixel-clock domain, back to 8-bit pixel data, DE and the two control bits. Owns word alignment: searches for control tokens during blanking and pulses `bitslip` to the deserializer until the symbol boundary is found, then holds lock. Three instances, one per channel, form a DVI receiver feeding the video capture path.

---
 rtl/tmds_channel_decoder_if.sv | 56 +++++
 rtl/tmds_channel_decoder.sv | 243 ++++++++++++++++++++++++
 tb/tb_tmds_channel_decoder.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tmds_channel_decoder_if.sv
// tmds_channel_decoder_if
// -----------------------
// Groups the symbol input and the decoded-video / alignment outputs of one
// TMDS channel decoder so that a DVI receiver can pass a single bundle per
// channel. Clock and reset are not part of the bundle.
//
// Signals:
//   din        [9:0]  raw 10-bit symbol from the 1:10 deserializer, din[0] first on the wire
//   bitslip           one-cycle request to the deserializer to move the word boundary by one bit
//   dout       [7:0]  decoded pixel byte
//   de                data enable, high for a data symbol decoded while locked
//   c          [1:0]  {C1,C0} from the most recent control token
//   locked            decoder has found and is holding the symbol boundary
//   lock_lost         one-cycle pulse when lock is dropped
//   slip_count [15:0] saturating count of bitslip pulses (only with TMDS_DEC_SLIP_STATS_EN)
//
// Modports:
//   master  the side that supplies symbols and consumes decoded video
//   slave   the decoder itself
//
// Optional feature macro: TMDS_DEC_SLIP_STATS_EN adds slip_count.

interface tmds_channel_decoder_if;
  logic [9:0] din;
  logic       bitslip;
  logic [7:0] dout;
  logic       de;
  logic [1:0] c;
  logic       locked;
  logic       lock_lost;

`ifdef TMDS_DEC_SLIP_STATS_EN
  logic [15:0] slip_count;

  modport master (
    output din,
    input  bitslip, dout, de, c, locked, lock_lost, slip_count
  );

  modport slave (
    input  din,
    output bitslip, dout, de, c, locked, lock_lost, slip_count
  );
`else
  modport master (
    output din,
    input  bitslip, dout, de, c, locked, lock_lost
  );

  modport slave (
    input  din,
    output bitslip, dout, de, c, locked, lock_lost
  );
`endif

endinterface

// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder
// --------------------
// Decodes one TMDS channel: 10-bit symbols from an external 1:10
// deserializer become 8-bit pixel data, DE and the two control bits.
// The block also owns word alignment. While searching it looks for a run
// of control tokens; if none shows up within a window it asks the
// deserializer to slip the word boundary by one bit, waits for the
// deserializer to settle, and searches again. Once locked it only drops
// lock after a long stretch without any control token.
//
// Pipeline: din -> s1_q (stage 1) -> decoded output registers (stage 2),
// so din to dout/de/c latency is two pixel clocks.
//
// Ports:
//   pixel_clock  sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   bus          tmds_channel_decoder_if.slave (din in; bitslip, dout, de,
//                c, locked, lock_lost out; slip_count out when enabled)
//
// Parameters:
//   CTRL_RUN        consecutive control tokens needed to declare lock
//   SEARCH_TIMEOUT  symbols examined in SEARCH before a bitslip
//   SLIP_SETTLE     cycles to ignore din after a bitslip
//   LOSS_TIMEOUT    consecutive data symbols while locked that drop lock
//
// Optional feature macro: TMDS_DEC_SLIP_STATS_EN adds a saturating 16-bit
// slip_count of issued bitslip pulses, cleared only by reset.

module tmds_channel_decoder #(
  parameter int unsigned CTRL_RUN       = 8,
  parameter int unsigned SEARCH_TIMEOUT = 1024,
  parameter int unsigned SLIP_SETTLE    = 4,
  parameter int unsigned LOSS_TIMEOUT   = 4096
) (
  input  logic                   pixel_clock,
  input  logic                   rst_n,
  tmds_channel_decoder_if.slave  bus
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SLIP   = 2'd1,
    SETTLE = 2'd2,
    LOCKED = 2'd3
  } state_t;

  localparam logic [9:0] TOKEN_C00 = 10'b1101010100;
  localparam logic [9:0] TOKEN_C01 = 10'b0010101011;
  localparam logic [9:0] TOKEN_C10 = 10'b0101010100;
  localparam logic [9:0] TOKEN_C11 = 10'b1010101011;

  localparam logic [15:0] RUN_LOCK    = 16'(CTRL_RUN);
  localparam logic [15:0] SEARCH_LAST = 16'(SEARCH_TIMEOUT - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SLIP_SETTLE - 1);
  localparam logic [15:0] LOSS_LIMIT  = 16'(LOSS_TIMEOUT);

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [15:0] satInc(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

  logic [9:0]  s1_q;
  state_t      state_q, state_d;
  logic [15:0] run_q, run_d;
  logic [15:0] word_q, word_d;
  logic [7:0]  dout_q, dout_d;
  logic        de_q, de_d;
  logic [1:0]  c_q, c_d;
  logic        lockLost_q, lockLost_d;

  logic        isToken;
  logic [1:0]  tokenC;
  logic [7:0]  dataD;
  logic [7:0]  decoded;

  // Stage 1: capture the raw symbol. Both the alignment FSM and the decoder
  // work from this registered copy.
  always_ff @(posedge pixel_clock or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
    end else begin
      s1_q <= bus.din;
    end
  end

  // Control token recognition on the stage-1 symbol.
  always_comb begin
    isToken = 1'b1;
    tokenC  = 2'b00;
    case (s1_q)
      TOKEN_C00: tokenC = 2'b00;
      TOKEN_C01: tokenC = 2'b01;
      TOKEN_C10: tokenC = 2'b10;
      TOKEN_C11: tokenC = 2'b11;
      default:   isToken = 1'b0;
    endcase
  end

  // Data symbol decode: undo the optional inversion (bit 9), then undo the
  // XOR / XNOR transition chain selected by bit 8.
  always_comb begin
    dataD      = s1_q[9] ? ~s1_q[7:0] : s1_q[7:0];
    decoded    = '0;
    decoded[0] = dataD[0];
    for (int i = 1; i < 8; i++) begin
      decoded[i] = s1_q[8] ? (dataD[i] ^ dataD[i-1]) : ~(dataD[i] ^ dataD[i-1]);
    end
  end

  // Alignment FSM state and counters. run counts consecutive tokens in
  // SEARCH; word is shared: symbols examined in SEARCH, settle cycles in
  // SETTLE, and consecutive data symbols in LOCKED.
  always_ff @(posedge pixel_clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SEARCH;
      run_q      <= '0;
      word_q     <= '0;
      lockLost_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      word_q     <= word_d;
      lockLost_q <= lockLost_d;
    end
  end

  // Next-state logic. Lock wins over the search timeout when both happen
  // on the same symbol. Losing lock returns straight to SEARCH without a
  // slip so the current alignment gets re-evaluated first.
  always_comb begin
    state_d    = state_q;
    run_d      = run_q;
    word_d     = word_q;
    lockLost_d = 1'b0;

    case (state_q)
      SEARCH: begin
        word_d = satInc(word_q);
        run_d  = isToken ? satInc(run_q) : '0;
        if (isToken && (satInc(run_q) >= RUN_LOCK)) begin
          state_d = LOCKED;
          run_d   = '0;
          word_d  = '0;
        end else if (word_q >= SEARCH_LAST) begin
          state_d = SLIP;
          run_d   = '0;
          word_d  = '0;
        end
      end

      SLIP: begin
        state_d = SETTLE;
        run_d   = '0;
        word_d  = '0;
      end

      SETTLE: begin
        word_d = satInc(word_q);
        if (word_q >= SETTLE_LAST) begin
          state_d = SEARCH;
          run_d   = '0;
          word_d  = '0;
        end
      end

      LOCKED: begin
        if (isToken) begin
          word_d = '0;
        end else begin
          word_d = satInc(word_q);
          if (satInc(word_q) >= LOSS_LIMIT) begin
            state_d    = SEARCH;
            lockLost_d = 1'b1;
            run_d      = '0;
            word_d     = '0;
          end
        end
      end

      default: begin
        state_d = SEARCH;
        run_d   = '0;
        word_d  = '0;
      end
    endcase
  end

  // Stage 2 output registers.
  always_ff @(posedge pixel_clock or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
      de_q   <= 1'b0;
      c_q    <= 2'b00;
    end else begin
      dout_q <= dout_d;
      de_q   <= de_d;
      c_q    <= c_d;
    end
  end

  // Output gating uses the next state, so de and the data path switch in
  // the same cycle as locked; de=1 therefore always implies locked=1.
  // Control bits follow tokens whether or not the channel is locked.
  always_comb begin
    dout_d = dout_q;
    de_d   = 1'b0;
    c_d    = c_q;

    if (isToken) begin
      c_d = tokenC;
    end

    if (state_d != LOCKED) begin
      dout_d = '0;
    end else if (!isToken) begin
      dout_d = decoded;
      de_d   = 1'b1;
    end
  end

`ifdef TMDS_DEC_SLIP_STATS_EN
  logic [15:0] slipCount_q;

  // Counts every cycle spent in SLIP, which is exactly one per bitslip pulse.
  always_ff @(posedge pixel_clock or negedge rst_n) begin
    if (!rst_n) begin
      slipCount_q <= '0;
    end else if (state_q == SLIP) begin
      slipCount_q <= satInc(slipCount_q);
    end
  end

  assign bus.slip_count = slipCount_q;
`endif

  assign bus.bitslip   = (state_q == SLIP);
  assign bus.locked    = (state_q == LOCKED);
  assign bus.lock_lost = lockLost_q;
  assign bus.dout      = dout_q;
  assign bus.de        = de_q;
  assign bus.c         = c_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb_tmds_channel_decoder
// -----------------------
// Self-checking bench for tmds_channel_decoder. A behavioural model written
// from the decoder's rules (token runs, search window, slip/settle, loss
// window) predicts every output each cycle. Directed phases cover reset,
// an aligned stream, control tokens, loss of lock and a 3-bit misaligned
// serial stream driven through a bitslip-honouring deserializer model;
// a random phase mixes tokens and arbitrary symbols.
// Optional feature macro: TMDS_DEC_SLIP_STATS_EN also checks slip_count.

module tb_tmds_channel_decoder;

  localparam int CTRL_RUN       = 8;
  localparam int SEARCH_TIMEOUT = 1024;
  localparam int SLIP_SETTLE    = 4;
  localparam int LOSS_TIMEOUT   = 4096;

  localparam logic [9:0] TOK0 = 10'b1101010100;
  localparam logic [9:0] TOK1 = 10'b0010101011;
  localparam logic [9:0] TOK2 = 10'b0101010100;
  localparam logic [9:0] TOK3 = 10'b1010101011;
  localparam logic [9:0] DATA_00 = 10'b0100000000;
  localparam logic [9:0] DATA_FF = 10'b1000000000;

  localparam int BLANK_LEN = 3600;

  logic clock = 1'b0;
  logic rst_n = 1'b0;

  tmds_channel_decoder_if bus ();

  tmds_channel_decoder #(
    .CTRL_RUN       (CTRL_RUN),
    .SEARCH_TIMEOUT (SEARCH_TIMEOUT),
    .SLIP_SETTLE    (SLIP_SETTLE),
    .LOSS_TIMEOUT   (LOSS_TIMEOUT)
  ) dut (
    .pixel_clock (clock),
    .rst_n       (rst_n),
    .bus         (bus)
  );

  always #5 clock = ~clock;

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model state
  logic [9:0] mS1;
  bit         mLocked;
  int         mRun;
  int         mSearchAge;
  int         mSlipAge;
  int         mDataRun;
  logic [7:0] expDout;
  logic       expDe;
  logic [1:0] expC;
  logic       expBitslip;
  logic       expLockLost;
  int         expSlipCount;

  logic [9:0] encSyms [256];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic int tokenOf(input logic [9:0] s);
    if (s == TOK0) return 0;
    if (s == TOK1) return 1;
    if (s == TOK2) return 2;
    if (s == TOK3) return 3;
    return -1;
  endfunction

  // Inverse of the TMDS transition-minimising stage.
  function automatic logic [7:0] refDecode(input logic [9:0] s);
    logic [7:0] q;
    logic [7:0] r;
    q = s[9] ? ~s[7:0] : s[7:0];
    r[0] = q[0];
    for (int i = 1; i < 8; i++) r[i] = q[i] ^ q[i-1] ^ ~s[8];
    return r;
  endfunction

  // DVI transmitter encoder with running disparity.
  function automatic logic [9:0] refEncode(input logic [7:0] d, inout int disparity);
    logic [8:0] qm;
    logic [9:0] sym;
    bit         useXnor;
    int         n1;
    int         n0;
    n1 = $countones(d);
    useXnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = useXnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = ~useXnor;
    n1 = $countones(qm[7:0]);
    n0 = 8 - n1;
    if (disparity == 0 || n1 == n0) begin
      sym = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      disparity += qm[8] ? (n1 - n0) : (n0 - n1);
    end else if ((disparity > 0 && n1 > n0) || (disparity < 0 && n0 > n1)) begin
      sym = {1'b1, qm[8], ~qm[7:0]};
      disparity += (qm[8] ? 2 : 0) + n0 - n1;
    end else begin
      sym = {1'b0, qm[8], qm[7:0]};
      disparity += (qm[8] ? 0 : -2) + n1 - n0;
    end
    return sym;
  endfunction

  task automatic modelReset();
    mS1          = '0;
    mLocked      = 1'b0;
    mRun         = 0;
    mSearchAge   = 0;
    mSlipAge     = -1;
    mDataRun     = 0;
    expDout      = '0;
    expDe        = 1'b0;
    expC         = 2'b00;
    expBitslip   = 1'b0;
    expLockLost  = 1'b0;
    expSlipCount = 0;
  endtask

  // One rising edge: mS1 is the symbol being judged, dinNow enters stage 1.
  task automatic modelStep(input logic [9:0] dinNow);
    int tok;
    bit wasSlipping;
    tok = tokenOf(mS1);
    wasSlipping = expBitslip;
    expLockLost = 1'b0;
    if (mLocked) begin
      mDataRun = (tok >= 0) ? 0 : mDataRun + 1;
      if (mDataRun >= LOSS_TIMEOUT) begin
        mLocked     = 1'b0;
        expLockLost = 1'b1;
        mDataRun    = 0;
        mRun        = 0;
        mSearchAge  = 0;
      end
    end else if (mSlipAge >= 0) begin
      mSlipAge++;
      if (mSlipAge > SLIP_SETTLE) begin
        mSlipAge   = -1;
        mRun       = 0;
        mSearchAge = 0;
      end
    end else begin
      mRun = (tok >= 0) ? mRun + 1 : 0;
      mSearchAge++;
      if (mRun >= CTRL_RUN) begin
        mLocked  = 1'b1;
        mDataRun = 0;
        mRun     = 0;
      end else if (mSearchAge >= SEARCH_TIMEOUT) begin
        mSlipAge = 0;
      end
    end
    expBitslip = (mSlipAge == 0);
    if (wasSlipping && expSlipCount < 65535) expSlipCount++;
    if (tok >= 0) expC = 2'(tok);
    if (!mLocked) begin
      expDe   = 1'b0;
      expDout = '0;
    end else if (tok >= 0) begin
      expDe = 1'b0;
    end else begin
      expDe   = 1'b1;
      expDout = refDecode(mS1);
    end
    mS1 = dinNow;
  endtask

  task automatic checkAll();
    checkOutput("bitslip",   32'(bus.bitslip),   32'(expBitslip));
    checkOutput("locked",    32'(bus.locked),    32'(mLocked));
    checkOutput("lock_lost", 32'(bus.lock_lost), 32'(expLockLost));
    checkOutput("de",        32'(bus.de),        32'(expDe));
    checkOutput("c",         32'(bus.c),         32'(expC));
    checkOutput("dout",      32'(bus.dout),      32'(expDout));
`ifdef TMDS_DEC_SLIP_STATS_EN
    checkOutput("slip_count", 32'(bus.slip_count), 32'(expSlipCount));
`endif
  endtask

  task automatic applyStimulus(input logic [9:0] value);
    bus.din = value;
    @(posedge clock);
    #1;
    modelStep(value);
    checkAll();
  endtask

  // Asserts reset away from a clock edge, checks the immediate effect,
  // keeps it asserted with random din, then releases mid-cycle.
  task automatic doReset(input int cycles);
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll();
    for (int n = 0; n < cycles; n++) begin
      bus.din = 10'($urandom);
      @(posedge clock);
      #1;
      checkAll();
    end
    rst_n = 1'b1;
  endtask

  function automatic logic [9:0] symAt(input int idx);
    if (idx < BLANK_LEN) return TOK0;
    if (idx < BLANK_LEN + 256) return encSyms[idx - BLANK_LEN];
    return TOK0;
  endfunction

  // Deserializer view of the serial stream: ten wire bits from a boundary
  // offset, din[0] being the earliest bit.
  function automatic logic [9:0] wordAt(input int k, input int offset);
    logic [9:0] w;
    logic [9:0] sym;
    int         pos;
    for (int b = 0; b < 10; b++) begin
      pos  = 10 * k + offset + b;
      sym  = symAt(pos / 10);
      w[b] = sym[pos % 10];
    end
    return w;
  endfunction

  task automatic runMisaligned();
    int offset;
    int slipAt[$];
    int gotBytes[$];
    offset = 7;
    doReset(3);
    for (int k = 0; k < BLANK_LEN + 256 + 40; k++) begin
      applyStimulus(wordAt(k, offset));
      if (bus.bitslip === 1'b1) begin
        slipAt.push_back(k);
        offset++;
      end
      if (bus.de === 1'b1) gotBytes.push_back(int'(bus.dout));
    end
    checkOutput("slipPulses", 32'(slipAt.size()), 32'd3);
    if (slipAt.size() > 0) checkOutput("firstSlip", 32'(slipAt[0]), 32'(SEARCH_TIMEOUT - 1));
    for (int i = 1; i < slipAt.size(); i++) begin
      checkOutput("slipSpacing", 32'(slipAt[i] - slipAt[i-1]), 32'(SEARCH_TIMEOUT + SLIP_SETTLE + 1));
    end
    checkOutput("bytesSeen", 32'(gotBytes.size()), 32'd256);
    for (int i = 0; i < gotBytes.size() && i < 256; i++) begin
      checkOutput("byteRoundTrip", 32'(gotBytes[i]), 32'(i));
    end
    checkOutput("lockedAfterAlign", 32'(bus.locked), 32'd1);
`ifdef TMDS_DEC_SLIP_STATS_EN
    checkOutput("slipStat", 32'(bus.slip_count), 32'd3);
`endif
  endtask

  initial begin
    int disparity;
    int lostPulses;
    int lostAt;
    logic [9:0] v;

    bus.din = '0;
    disparity = 0;
    for (int i = 0; i < 256; i++) encSyms[i] = refEncode(8'(i), disparity);

    // Reset with random din
    #2;
    doReset(5);

    // Aligned stream: lock after the 9th edge, then data with 2-cycle latency
    for (int i = 0; i < CTRL_RUN; i++) applyStimulus(TOK0);
    checkOutput("notYetLocked", 32'(bus.locked), 32'd0);
    applyStimulus(DATA_00);
    checkOutput("lockAfter9", 32'(bus.locked), 32'd1);
    applyStimulus(DATA_FF);
    checkOutput("dout00", 32'(bus.dout), 32'h00);
    checkOutput("deData", 32'(bus.de), 32'd1);

    // Control tokens while locked: c follows, de low, dout held
    applyStimulus(TOK1);
    checkOutput("doutFF", 32'(bus.dout), 32'hFF);
    applyStimulus(TOK2);
    checkOutput("c01", 32'(bus.c), 32'd1);
    checkOutput("deToken", 32'(bus.de), 32'd0);
    checkOutput("doutHeld", 32'(bus.dout), 32'hFF);
    applyStimulus(TOK3);
    checkOutput("c10", 32'(bus.c), 32'd2);
    applyStimulus(TOK0);
    checkOutput("c11", 32'(bus.c), 32'd3);
    applyStimulus(TOK0);
    checkOutput("c00", 32'(bus.c), 32'd0);

    // A token arriving at data word 4095 keeps lock
    for (int i = 0; i < LOSS_TIMEOUT - 1; i++) applyStimulus(DATA_00);
    applyStimulus(TOK0);
    applyStimulus(TOK0);
    checkOutput("lockKeptByToken", 32'(bus.locked), 32'd1);

    // 4096 consecutive data symbols drop lock with a single pulse
    lostPulses = 0;
    lostAt = -1;
    for (int n = 1; n <= LOSS_TIMEOUT + 4; n++) begin
      applyStimulus(DATA_00);
      if (bus.lock_lost === 1'b1) begin
        lostPulses++;
        lostAt = n;
        checkOutput("lockedAtLoss", 32'(bus.locked), 32'd0);
        checkOutput("deAtLoss", 32'(bus.de), 32'd0);
      end
    end
    checkOutput("lossPulses", 32'(lostPulses), 32'd1);
    checkOutput("lossCycle", 32'(lostAt), 32'(LOSS_TIMEOUT + 1));

    // Random mix of tokens and arbitrary symbols
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 9) < 6) begin
        case ($urandom_range(0, 3))
          0: v = TOK0;
          1: v = TOK1;
          2: v = TOK2;
          default: v = TOK3;
        endcase
      end else begin
        v = 10'($urandom);
      end
      applyStimulus(v);
    end

    // Reset mid-stream, then the 3-bit misaligned serial link
    doReset(4);
    runMisaligned();

    // Reset after slips clears everything again
    doReset(2);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
